rx_buffer_ctrl: RTL

- Sits between the receiver grand-module and the host-side consumer.
- Captures each completed frame (data byte, parity error, frame error) on the receiver's frame-done indication and queues it in a small FIFO.
- Presents queued frames to the consumer over a valid/ready handshake.
- Tracks overrun and error statistics; optionally flags an idle timeout measured in 16x baud ticks.

---
 rtl/rx_buffer_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rx_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rx_buffer_ctrl
//  Purpose  : Receive-side frame buffer. Captures each completed frame
//             {Rx_err, parity_error, rx_data} on the rising edge of Rx_done,
//             queues it in a small FIFO and hands it to the consumer over a
//             valid/ready handshake. Tracks a sticky overrun flag and a
//             saturating error-frame counter.
//  Options  : RX_TIMEOUT_EN - when defined, an idle counter of Bclkx16_
//             ticks raises `timeout` while frames sit unconsumed.
//  Revision : 1.0 - initial release
// ============================================================================
module rx_buffer_ctrl #(
  parameter int DEPTH         = 4,
  parameter int TIMEOUT_TICKS = 640,
  parameter int CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Bclkx16_,
  input  logic                     Rx_done,
  input  logic [7:0]               rx_data,
  input  logic                     parity_error,
  input  logic                     Rx_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [1:0]               out_status,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overrun,
  output logic [CNT_W-1:0]         err_cnt,
  input  logic                     clr_err,
  output logic                     timeout
);

  localparam int               c_AW      = $clog2(DEPTH);
  localparam int               c_CW      = c_AW + 1;
  localparam logic [c_CW-1:0]  c_FULL    = c_CW'(DEPTH);
  localparam logic [CNT_W-1:0] c_ERR_MAX = '1;

  logic              r_rx_done_q;
  logic [9:0]        r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic [9:0]        r_last;
  logic              r_overrun;
  logic [CNT_W-1:0]  r_err_cnt;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_accept;
  logic              w_has_err;
  logic [9:0]        w_head;

  // One push per Rx_done high period; a level already high after reset counts
  // as a fresh edge because the delayed copy reloads to 0.
  assign w_push    = Rx_done & ~r_rx_done_q;
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  assign w_full    = (r_count == c_FULL);
  // When full, the slot freed by a same-cycle pop takes the new frame.
  assign w_accept  = w_push & (~w_full | w_pop);
  assign w_has_err = parity_error | Rx_err;

  // Head entry while occupied, otherwise the last entry handed out (0 after reset).
  assign w_head     = out_valid ? r_mem[r_rd_ptr] : r_last;
  assign out_data   = w_head[7:0];
  assign out_status = w_head[9:8];
  assign fifo_count = r_count;
  assign overrun    = r_overrun;
  assign err_cnt    = r_err_cnt;

  // Frame-done edge detector register.
  always_ff @(posedge clk) begin
    if (rst) r_rx_done_q <= 1'b0;
    else     r_rx_done_q <= Rx_done;
  end

  // Storage array; contents are only meaningful where pointers say so.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) r_mem[r_wr_ptr] <= {Rx_err, parity_error, rx_data};
  end

  // Pointers, occupancy and the held copy of the last popped entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overrun and saturating error counter; clear takes priority.
  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      r_overrun <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
      if (w_push && w_has_err && (r_err_cnt != c_ERR_MAX))
        r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int              c_TW     = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [c_TW-1:0] c_TMO    = c_TW'(TIMEOUT_TICKS);

  logic [c_TW-1:0] r_idle;
  logic            r_timeout;
  logic            w_idle_clr;

  assign w_idle_clr = w_push | w_pop | ~out_valid;
  assign timeout    = r_timeout;

  // Idle counter of baud ticks while frames wait; parks at the limit.
  always_ff @(posedge clk) begin
    if (rst || w_idle_clr)                 r_idle <= '0;
    else if (Bclkx16_ && (r_idle != c_TMO)) r_idle <= r_idle + c_TW'(1);
  end

  // Timeout flag follows the counter reaching its limit by one cycle.
  always_ff @(posedge clk) begin
    if (rst || w_idle_clr) r_timeout <= 1'b0;
    else                   r_timeout <= (r_idle == c_TMO);
  end
`else
  logic w_unused_tmo;

  assign w_unused_tmo = Bclkx16_ & (TIMEOUT_TICKS > 0);
  assign timeout      = 1'b0;
`endif

endmodule
`default_nettype wire
